// File: rtl/uwire_rx_monitor.sv
// uwire_rx_monitor: MICROWIRE frame receiver with shadow register file, readback and frame/error counters
module uwire_rx_monitor #(
  parameter int REG_SIZE    = 32,
  parameter int ADDR_BITS   = 5,
  parameter int NUM_REGS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 CLKuWire,
  input  logic                 DATAuWire,
  input  logic                 LEuWire,
  output logic [REG_SIZE-1:0]  word,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [REG_SIZE-1:0]  rd_data
);
  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;
  localparam logic [5:0] FULL_CNT = 6'(REG_SIZE);
  state_t st, st_a, st_n;
  logic [SYNC_STAGES-1:0] clk_s, dat_s, le_s;
  logic clk_h, le_h, clk_rise, le_rise, shift, commit, err;
  logic [5:0] bitcnt, cnt_a, cnt_n;
  logic [REG_SIZE-1:0] shreg, shreg_n;
  logic [REG_SIZE-1:0] shadow [NUM_REGS];
  logic [ADDR_BITS-1:0] waddr;
  assign clk_rise = clk_s[SYNC_STAGES-1] & ~clk_h;
  assign le_rise  = le_s[SYNC_STAGES-1] & ~le_h;
  assign waddr    = shreg_n[ADDR_BITS-1:0];
  // bring the asynchronous uWire pins into CLK and keep one cycle of history for edge detection
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      clk_s <= '0;
      dat_s <= '0;
      le_s  <= '0;
      clk_h <= 1'b0;
      le_h  <= 1'b0;
    end else begin
      clk_s <= {clk_s[SYNC_STAGES-2:0], CLKuWire};
      dat_s <= {dat_s[SYNC_STAGES-2:0], DATAuWire};
      le_s  <= {le_s[SYNC_STAGES-2:0], LEuWire};
      clk_h <= clk_s[SYNC_STAGES-1];
      le_h  <= le_s[SYNC_STAGES-1];
    end
  end
  // clock edge is applied first, then the latch edge judges the resulting state
  always_comb begin
    shift   = clk_rise && (st == IDLE || st == SHIFT);
    cnt_a   = shift ? bitcnt + 6'd1 : bitcnt;
    shreg_n = shift ? {shreg[REG_SIZE-2:0], dat_s[SYNC_STAGES-1]} : shreg;
    st_a    = !clk_rise ? st : (st == FULL || st == OVER) ? OVER : (cnt_a == FULL_CNT) ? FULL : SHIFT;
    commit  = le_rise && st_a == FULL;
    err     = le_rise && (st_a == SHIFT || st_a == OVER);
    st_n    = le_rise ? IDLE : st_a;
    cnt_n   = le_rise ? 6'd0 : cnt_a;
  end
  // frame state, shifter, committed word, pulses and counters
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      st         <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      st         <= st_n;
      bitcnt     <= cnt_n;
      shreg      <= shreg_n;
      word       <= commit ? shreg_n : word;
      word_valid <= commit;
      frame_err  <= err;
      frame_cnt  <= commit ? frame_cnt + 16'd1 : frame_cnt;
      err_cnt    <= (err && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
  end
  // shadow file written on commit for in-range addresses; readback registered
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      rd_data <= '0;
    end else begin
      if (commit && 32'(waddr) < NUM_REGS) shadow[waddr] <= shreg_n;
      rd_data <= (32'(rd_addr) < NUM_REGS) ? shadow[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_uwire_rx_monitor.sv
// tb_uwire_rx_monitor: directed checks of frame decode, errors, readback, reset and counter limits
module tb_uwire_rx_monitor;
  logic CLK = 0, rst_n = 0, CLKuWire = 0, DATAuWire = 0, LEuWire = 0;
  logic [31:0] word, rd_data;
  logic word_valid, frame_err;
  logic [15:0] frame_cnt;
  logic [7:0] err_cnt;
  logic [4:0] rd_addr = 0;
  int n_chk = 0, n_fail = 0, wv = 0, fe = 0, wv0, fe0;

  uwire_rx_monitor dut (
    .CLK(CLK), .rst_n(rst_n), .CLKuWire(CLKuWire), .DATAuWire(DATAuWire), .LEuWire(LEuWire),
    .word(word), .word_valid(word_valid), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    wv += int'(word_valid);
    fe += int'(frame_err);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DATAuWire = v[i];
      #40 CLKuWire = 1;
      #40 CLKuWire = 0;
    end
  endtask

  task automatic pulse_le();
    #40 LEuWire = 1;
    #40 LEuWire = 0;
    #80 @(negedge CLK);
  endtask

  task automatic send_frame(input logic [31:0] v);
    send_bits({32'h0, v}, 32);
    pulse_le();
  endtask

  task automatic read_shadow(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    @(negedge CLK);
    check(tag, rd_data, exp);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(negedge CLK);
    rst_n = 1;
    @(negedge CLK);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    do_reset();
    check("rst_word", word, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_word_valid", {31'h0, word_valid}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 0);
    check("rst_err_cnt", {24'h0, err_cnt}, 0);

    wv0 = wv; fe0 = fe;
    send_frame(32'h0140_0000);
    send_frame(32'h8000_0006);
    check("two_frames_valid_pulses", wv - wv0, 2);
    check("two_frames_no_err", fe - fe0, 0);
    check("two_frames_word", word, 32'h8000_0006);
    check("two_frames_cnt", {16'h0, frame_cnt}, 2);
    read_shadow(0, 32'h0140_0000, "shadow0");
    read_shadow(6, 32'h8000_0006, "shadow6");

    wv0 = wv; fe0 = fe;
    pulse_le();
    check("idle_le_no_err", fe - fe0, 0);
    check("idle_le_no_valid", wv - wv0, 0);
    check("idle_le_err_cnt", {24'h0, err_cnt}, 0);

    wv0 = wv; fe0 = fe;
    send_bits(64'hABCDE, 20);
    pulse_le();
    check("short_err_pulse", fe - fe0, 1);
    check("short_no_valid", wv - wv0, 0);
    check("short_err_cnt", {24'h0, err_cnt}, 1);
    check("short_word_kept", word, 32'h8000_0006);
    send_frame(32'h1234_5671);
    read_shadow(17, 32'h1234_5671, "shadow17");
    check("after_short_cnt", {16'h0, frame_cnt}, 3);

    wv0 = wv; fe0 = fe;
    send_bits(64'h1_5555_AAAA, 33);
    pulse_le();
    check("long_err_pulse", fe - fe0, 1);
    check("long_no_valid", wv - wv0, 0);
    check("long_err_cnt", {24'h0, err_cnt}, 2);
    check("long_word_kept", word, 32'h1234_5671);
    send_frame(32'h0000_0025);
    check("after_long_word", word, 32'h0000_0025);
    check("after_long_cnt", {16'h0, frame_cnt}, 4);
    read_shadow(5, 32'h0000_0025, "shadow5");

    wv0 = wv; fe0 = fe;
    send_bits({32'h0, 32'hDEAD_BEE3} >> 1, 31);
    DATAuWire = 1'b1;
    #40 CLKuWire = 1; LEuWire = 1;
    #40 CLKuWire = 0; LEuWire = 0;
    #80 @(negedge CLK);
    check("sim_edge_valid", wv - wv0, 1);
    check("sim_edge_no_err", fe - fe0, 0);
    check("sim_edge_word", word, 32'hDEAD_BEE3);
    read_shadow(3, 32'hDEAD_BEE3, "shadow3");

    send_bits(64'hFFFF, 16);
    #40 do_reset();
    wv0 = wv; fe0 = fe;
    send_frame(32'h0000_00A9);
    check("rst_mid_frame_cnt", {16'h0, frame_cnt}, 1);
    check("rst_mid_err_cnt", {24'h0, err_cnt}, 0);
    check("rst_mid_no_err", fe - fe0, 0);
    check("rst_mid_word", word, 32'h0000_00A9);
    read_shadow(9, 32'h0000_00A9, "shadow9");
    read_shadow(3, 32'h0, "shadow3_cleared");

    for (int k = 0; k < 255; k++) begin
      send_bits(64'h1, 1);
      pulse_le();
    end
    check("err_cnt_255", {24'h0, err_cnt}, 32'hFF);
    send_bits(64'h0, 1);
    pulse_le();
    check("err_cnt_saturated", {24'h0, err_cnt}, 32'hFF);
    check("sat_frame_cnt", {16'h0, frame_cnt}, 1);
    check("sat_word_kept", word, 32'h0000_00A9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
